// File: rtl/wb_trace_checker.sv
// wb_trace_checker
//   Consumer end of the writeback debug trace. Golden entries arrive over a
//   valid/ready handshake and wait in a small FIFO. In RUN, every CPU register
//   write (any byte lane enabled, wnum != 0) pops the head entry and compares
//   it against the CPU write. The first error is captured and held. A clean
//   end of trace is reported as a sticky pass.
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   start              one-cycle pulse, IDLE -> RUN
//   debug_wb_*         CPU writeback trace (pc, byte-lane wen, wnum, wdata)
//   ref_valid/ready    golden-entry handshake; ref_pc/wnum/wdata is the payload
//   ref_end            level, latched; the golden source has no more entries
//   pass, err          sticky status
//   err_code           0 none, 1 mismatch, 2 underflow, 3 timeout
//   err_pc/exp/act     context for the first error
//   match_count        matched write events (wraps)
//   fifo_count         current FIFO occupancy
module wb_trace_checker #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [31:0]                debug_wb_pc,
  input  logic [3:0]                 debug_wb_rf_wen,
  input  logic [4:0]                 debug_wb_rf_wnum,
  input  logic [31:0]                debug_wb_rf_wdata,
  input  logic                       ref_valid,
  output logic                       ref_ready,
  input  logic [31:0]                ref_pc,
  input  logic [4:0]                 ref_wnum,
  input  logic [31:0]                ref_wdata,
  input  logic                       ref_end,
  output logic                       pass,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [31:0]                err_pc,
  output logic [31:0]                err_exp,
  output logic [31:0]                err_act,
  output logic [31:0]                match_count,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERROR, S_PASS} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } gold_t;

  localparam logic [1:0] E_NONE = 2'd0, E_MISMATCH = 2'd1,
                         E_UNDERFLOW = 2'd2, E_TIMEOUT = 2'd3;

  state_t             state_q, state_d;
  gold_t              mem_q [DEPTH], mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               end_q, end_d;
  logic [TW-1:0]      idle_q, idle_d;
  logic [31:0]        last_pc_q, last_pc_d;
  logic               pass_q, pass_d, err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic [31:0]        epc_q, epc_d, eexp_q, eexp_d, eact_q, eact_d;
  logic [31:0]        match_q, match_d;

  logic               full, empty, push, pop, wr_ev, hit;
  gold_t              head, in_ent;
  logic [NUM_LANES-1:0] lane_ok;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign ref_ready = !full && (state_q != S_ERROR) && (state_q != S_PASS);
  assign push   = ref_valid && ref_ready;
  assign wr_ev  = (|debug_wb_rf_wen) && (debug_wb_rf_wnum != 5'd0);
  assign head   = mem_q[rd_ptr_q];
  assign in_ent = '{pc: ref_pc, wnum: ref_wnum, wdata: ref_wdata};

  // Disabled byte lanes are don't-care in the data compare.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_ok[i] = !debug_wb_rf_wen[i] ||
                        (debug_wb_rf_wdata[8*i +: 8] == head.wdata[8*i +: 8]);
  end
  assign hit = (&lane_ok) && (debug_wb_pc == head.pc) &&
               (debug_wb_rf_wnum == head.wnum);

  always_comb begin
    state_d   = state_q;
    end_d     = end_q | ref_end;
    idle_d    = idle_q;
    last_pc_d = last_pc_q;
    pass_d    = pass_q;
    err_d     = err_q;
    code_d    = code_q;
    epc_d     = epc_q;
    eexp_d    = eexp_q;
    eact_d    = eact_q;
    match_d   = match_q;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          idle_d  = '0;
        end
      end
      S_RUN: begin
        if (wr_ev) begin
          idle_d = '0;
          if (empty) begin
            // No bypass: a push in this same cycle cannot satisfy the event.
            state_d = S_ERROR;
            err_d   = 1'b1;
            code_d  = E_UNDERFLOW;
            epc_d   = debug_wb_pc;
            eact_d  = debug_wb_rf_wdata;
          end else begin
            pop = 1'b1;
            if (hit) begin
              match_d   = match_q + 32'd1;
              last_pc_d = debug_wb_pc;
            end else begin
              state_d = S_ERROR;
              err_d   = 1'b1;
              code_d  = E_MISMATCH;
              epc_d   = debug_wb_pc;
              eexp_d  = head.wdata;
              eact_d  = debug_wb_rf_wdata;
            end
          end
        end else if (idle_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
          code_d  = E_TIMEOUT;
          epc_d   = last_pc_q;
        end else begin
          idle_d = idle_q + TW'(1);
          if (end_q && empty) begin
            state_d = S_PASS;
            pass_d  = 1'b1;
          end
        end
      end
      default: ;  // ERROR / PASS hold until reset
    endcase

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_ent;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      end_q     <= 1'b0;
      idle_q    <= '0;
      last_pc_q <= '0;
      pass_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= E_NONE;
      epc_q     <= '0;
      eexp_q    <= '0;
      eact_q    <= '0;
      match_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      end_q     <= end_d;
      idle_q    <= idle_d;
      last_pc_q <= last_pc_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      code_q    <= code_d;
      epc_q     <= epc_d;
      eexp_q    <= eexp_d;
      eact_q    <= eact_d;
      match_q   <= match_d;
    end
  end

  // Storage is only meaningful behind the pointers, so it needs no reset.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign pass        = pass_q;
  assign err         = err_q;
  assign err_code    = code_q;
  assign err_pc      = epc_q;
  assign err_exp     = eexp_q;
  assign err_act     = eact_q;
  assign match_count = match_q;
  assign fifo_count  = count_q;

endmodule

// File: doc/wb_trace_checker.md
Name: wb_trace_checker

Overview:
Consumer end of the writeback debug interface. The CPU writeback stage drives the per-retirement trace (debug_wb_pc, 4-bit byte-lane write enable, register number, write data), with duplicate-PC writes already suppressed upstream. This block receives a golden trace stream through a valid/ready handshake, buffers it in a FIFO, and compares each CPU register write against the next golden entry. It reports pass, first error and match count to the testbench/board top.

Parameters:
DEPTH, 16, golden-entry FIFO depth; power of two, >= 2
TIMEOUT, 1024, RUN-state cycles without a write event before a timeout error; >= 1

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; IDLE -> RUN
debug_wb_pc  in  32  PC of retiring instruction
debug_wb_rf_wen  in  4  byte-lane write enable; bit i covers wdata[8i+7:8i]
debug_wb_rf_wnum  in  5  destination register
debug_wb_rf_wdata  in  32  write data
ref_valid  in  1  golden entry valid
ref_ready  out  1  FIFO can accept an entry
ref_pc  in  32  golden PC
ref_wnum  in  5  golden register number
ref_wdata  in  32  golden data
ref_end  in  1  level; golden source has no further entries
pass  out  1  sticky; trace fully matched
err  out  1  sticky; first error captured
err_code  out  2  0 none, 1 mismatch, 2 underflow, 3 timeout
err_pc  out  32  CPU PC at first error (timeout: last matched PC)
err_exp  out  32  golden wdata at mismatch, else 0
err_act  out  32  CPU wdata at mismatch or underflow, else 0
match_count  out  32  matched write events, wraps at 2^32
fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (synchronous, active-high): state=IDLE; FIFO empty; pass=0; err=0; err_code=0; err_pc=err_exp=err_act=0; match_count=0; idle counter=0; ref_end latch=0.
- Push: when ref_valid && ref_ready. ref_ready = !full && state!=ERROR && state!=PASS. Push is accepted in IDLE as well, allowing the FIFO to be prefilled.
- ref_end is latched into a sticky flag on any cycle it is high.
- Write event: (|debug_wb_rf_wen) && debug_wb_rf_wnum!=0. Events are counted only in RUN.
- IDLE: events are ignored; start=1 -> RUN and idle counter cleared.
- RUN, on each event:
  - FIFO empty -> ERROR, code 2. There is no bypass: an entry pushed in the same cycle does not satisfy the event.
  - Otherwise the head entry is popped and compared: pc equal, wnum equal, and each enabled byte lane equal (disabled lanes are don't-care).
  - All equal -> match_count+1.
  - Any field differs -> ERROR, code 1; err_exp=head wdata, err_act=CPU wdata.
- Simultaneous push and pop in one cycle: occupancy unchanged. Push and pop pointers wrap modulo DEPTH.
- RUN, no event: idle counter +1. If the counter equals TIMEOUT-1 in a no-event cycle -> ERROR, code 3. An error is therefore registered after exactly TIMEOUT consecutive event-free cycles. Any event clears the counter.
- RUN -> PASS when the ref_end latch=1, the FIFO is empty and no event occurs this cycle. An event with an empty FIFO is underflow, not PASS.
- Error priority within one cycle: mismatch/underflow over timeout over PASS.
- ERROR and PASS are terminal until reset. Only the first error is captured; err/pass outputs change on the edge that enters the state (one-cycle latency from the triggering event).
- Reset asserted mid-RUN discards FIFO contents and all captured status on that edge.

Test Plan:
- Prefill 3 entries (pc 0xbfc00000/04/08, wnum 1/2/3, data 0x11/0x22/0x33), start, drive matching events on 3 cycles, assert ref_end -> match_count=3, pass=1 one cycle after the FIFO empties, err=0.
- Golden data 0xAABBCCDD, CPU wen=4'b0011, wdata 0x0000CCDD -> match. Same entry with wen=4'b1111 -> err=1, code 1, err_exp=0xAABBCCDD, err_act=0x0000CCDD.
- Empty FIFO, event pc 0xbfc00010, with ref_valid pushed the same cycle -> code 2, err_pc=0xbfc00010; the pushed entry stays in the FIFO.
- TIMEOUT=8, RUN with no events -> err rises on the edge after the 8th idle cycle, code 3. Repeat with an event at cycle 7 -> no error.
- Push DEPTH+2 entries with ref_valid held high -> ref_ready=0 at fifo_count=DEPTH; pop one -> ready returns and the next push is accepted with occupancy unchanged during the simultaneous push/pop.
- Events with wnum=0 or wen=0 in RUN are ignored (match_count unchanged, idle counter increments). Reset pulsed mid-RUN -> all outputs return to reset values next cycle.
